// File: rtl/dm_sba.sv
// rtl/dm_sba.sv - debug module system bus access manager (sbcs/sbaddress0/sbdata0 to req/ack bus)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   dmactive              0 synchronously returns the block to its reset state
//   dmi_req_*             one-cycle register access strobe from the DM decoder
//   dmi_rdata             combinational read data for dmi_req_addr
//   bus_req/we/addr/wdata/be   system bus master request, held until completion
//   bus_ack/rdata/err     system bus completion
// Optional feature macro: DM_SBA_TIMEOUT_EN (bus timeout counter of TIMEOUT_CYCLES)
module dm_sba #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmactive,
    input  logic        dmi_req_valid,
    input  logic [7:0]  dmi_req_addr,
    input  logic        dmi_req_write,
    input  logic [31:0] dmi_req_wdata,
    output logic [31:0] dmi_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam logic [7:0] ADDR_SBCS       = 8'h38;
    localparam logic [7:0] ADDR_SBADDRESS0 = 8'h39;
    localparam logic [7:0] ADDR_SBDATA0    = 8'h3c;

    localparam logic [2:0] SBE_NONE      = 3'd0;
    localparam logic [2:0] SBE_TIMEOUT   = 3'd1;
    localparam logic [2:0] SBE_ADDRESS   = 3'd2;
    localparam logic [2:0] SBE_ALIGNMENT = 3'd3;
    localparam logic [2:0] SBE_SIZE      = 3'd4;

    localparam logic [2:0] SBA_8BIT  = 3'd0;
    localparam logic [2:0] SBA_16BIT = 3'd1;
    localparam logic [2:0] SBA_32BIT = 3'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    state_e      state_q, state_d;

    logic        readonaddr_q;
    logic        autoinc_q;
    logic        readondata_q;
    logic        busyerror_q;
    logic [2:0]  access_q;
    logic [2:0]  error_q;
    logic [31:0] address_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;

    logic        busy;
    logic        wr_sbcs, wr_addr, wr_data, rd_data;
    logic        trig_read, trig_write, trig;
    logic        can_start, size_bad, align_bad, start;
    logic [31:0] start_addr, start_data, lane_data;
    logic [3:0]  lane_mask;
    logic        timeout_hit;
    logic        done_ack, done_err, done_to;
    logic [31:0] rd_shift, rd_ext;

    assign busy    = (state_q == BUS);
    assign bus_req = busy;

    assign wr_sbcs = dmi_req_valid &&  dmi_req_write && (dmi_req_addr == ADDR_SBCS);
    assign wr_addr = dmi_req_valid &&  dmi_req_write && (dmi_req_addr == ADDR_SBADDRESS0);
    assign wr_data = dmi_req_valid &&  dmi_req_write && (dmi_req_addr == ADDR_SBDATA0);
    assign rd_data = dmi_req_valid && !dmi_req_write && (dmi_req_addr == ADDR_SBDATA0);

    // A start uses the value being written in the same cycle, not the stale register.
    assign trig_read  = !busy && ((wr_addr && readonaddr_q) || (rd_data && readondata_q));
    assign trig_write = !busy && wr_data;
    assign can_start  = !busyerror_q && (error_q == SBE_NONE);
    assign trig       = (trig_read || trig_write) && can_start;
    assign start      = trig && !size_bad && !align_bad;

    always_comb begin
        start_addr = wr_addr ? dmi_req_wdata : address_q;
        start_data = wr_data ? dmi_req_wdata : data_q;
        size_bad   = (access_q > SBA_32BIT);
        align_bad  = 1'b0;
        lane_mask  = 4'b1111;
        lane_data  = start_data;
        case (access_q)
            SBA_8BIT: begin
                lane_mask = 4'b0001;
                lane_data = {4{start_data[7:0]}};
            end
            SBA_16BIT: begin
                align_bad = start_addr[0];
                lane_mask = 4'b0011;
                lane_data = {2{start_data[15:0]}};
            end
            default: align_bad = |start_addr[1:0];
        endcase
    end

    // Completion priority: err beats ack, ack beats timeout.
    assign done_err = busy && bus_err;
    assign done_ack = busy && bus_ack && !bus_err;
    assign done_to  = busy && timeout_hit && !bus_ack && !bus_err;

    // Read lanes come from the latched address/size so a mid-transaction sbcs
    // write cannot change how the returning data is extracted.
    assign rd_shift = bus_rdata >> {bus_addr[1:0], 3'b000};
    always_comb begin
        rd_ext = rd_shift;
        case (size_q)
            2'd0:    rd_ext = {24'd0, rd_shift[7:0]};
            2'd1:    rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

`ifdef DM_SBA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt_q;

    // Held at 0 while idle so it restarts from 0 on every entry to BUS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (!dmactive || !busy) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = busy && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (!dmactive) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUS;
            BUS:     if (bus_ack || bus_err || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readonaddr_q <= 1'b0;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            busyerror_q  <= 1'b0;
            access_q     <= SBA_8BIT;
            error_q      <= SBE_NONE;
            address_q    <= '0;
            data_q       <= '0;
            size_q       <= '0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
        end else if (!dmactive) begin
            readonaddr_q <= 1'b0;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            busyerror_q  <= 1'b0;
            access_q     <= SBA_8BIT;
            error_q      <= SBE_NONE;
            address_q    <= '0;
            data_q       <= '0;
            size_q       <= '0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
        end else begin
            if (wr_sbcs) begin
                readonaddr_q <= dmi_req_wdata[20];
                access_q     <= dmi_req_wdata[19:17];
                autoinc_q    <= dmi_req_wdata[16];
                readondata_q <= dmi_req_wdata[15];
                if (dmi_req_wdata[22]) busyerror_q <= 1'b0;
                error_q <= error_q & ~dmi_req_wdata[14:12];
            end

            if (busy && (wr_addr || wr_data || rd_data)) busyerror_q <= 1'b1;
            if (!busy && wr_addr) address_q <= dmi_req_wdata;
            if (!busy && wr_data) data_q    <= dmi_req_wdata;

            if (trig && size_bad) begin
                error_q <= SBE_SIZE;
            end else if (trig && align_bad) begin
                error_q <= SBE_ALIGNMENT;
            end

            if (start) begin
                bus_we    <= trig_write;
                bus_addr  <= start_addr;
                bus_be    <= lane_mask << start_addr[1:0];
                bus_wdata <= lane_data;
                size_q    <= access_q[1:0];
            end

            // Placed after the W1C update so an error raised this cycle survives it.
            if (done_ack) begin
                if (!bus_we) data_q <= rd_ext;
                if (autoinc_q) address_q <= address_q + (32'd1 << size_q);
            end
            if (done_err) error_q <= SBE_ADDRESS;
            if (done_to)  error_q <= SBE_TIMEOUT;
        end
    end

    always_comb begin
        dmi_rdata = '0;
        case (dmi_req_addr)
            ADDR_SBCS: dmi_rdata = {3'd1, 6'd0, busyerror_q, busy, readonaddr_q, access_q,
                                    autoinc_q, readondata_q, error_q, 7'd32, 5'b00111};
            ADDR_SBADDRESS0: dmi_rdata = address_q;
            ADDR_SBDATA0:    dmi_rdata = data_q;
            default:         dmi_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dm_sba.sv
// tb/tb_dm_sba.sv - scoreboard testbench for dm_sba
module tb_dm_sba;

    localparam int unsigned TO = 8;
    localparam logic [7:0] A_SBCS = 8'h38;
    localparam logic [7:0] A_ADDR = 8'h39;
    localparam logic [7:0] A_DATA = 8'h3c;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmactive;
    logic        dmi_req_valid;
    logic [7:0]  dmi_req_addr;
    logic        dmi_req_write;
    logic [31:0] dmi_req_wdata;
    logic [31:0] dmi_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    dm_sba #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmactive      (dmactive),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_write (dmi_req_write),
        .dmi_req_wdata (dmi_req_wdata),
        .dmi_rdata     (dmi_rdata),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    string       exp_name[$];
    logic [31:0] exp_val[$];
    logic [31:0] obs_q[$];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] rd;

    task automatic push_exp(input string n, input logic [31:0] v);
        exp_name.push_back(n);
        exp_val.push_back(v);
    endtask

    task automatic dmi_write(input logic [7:0] a, input logic [31:0] d);
        dmi_req_valid = 1'b1; dmi_req_write = 1'b1; dmi_req_addr = a; dmi_req_wdata = d;
        @(negedge clk);
        dmi_req_valid = 1'b0; dmi_req_write = 1'b0;
    endtask

    task automatic dmi_read(input logic [7:0] a, output logic [31:0] d);
        dmi_req_valid = 1'b1; dmi_req_write = 1'b0; dmi_req_addr = a;
        #1 d = dmi_rdata;
        @(negedge clk);
        dmi_req_valid = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        dmi_req_valid = 1'b0; dmi_req_addr = a;
        #1 d = dmi_rdata;
    endtask

    task automatic bus_respond(input logic ack, input logic err, input logic [31:0] data);
        bus_ack = ack; bus_err = err; bus_rdata = data;
        @(negedge clk);
        bus_ack = 1'b0; bus_err = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; dmactive = 1'b0; dmi_req_valid = 1'b0; dmi_req_write = 1'b0;
        dmi_req_addr = '0; dmi_req_wdata = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; dmactive = 1'b1;
        @(negedge clk);
        push_exp("rst_sbcs", 32'h2000_0407); peek(A_SBCS, rd); obs_q.push_back(rd);
        push_exp("rst_addr", 32'h0);         peek(A_ADDR, rd); obs_q.push_back(rd);
        push_exp("rst_data", 32'h0);         peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("rst_other", 32'h0);        peek(8'h3d, rd);  obs_q.push_back(rd);
        push_exp("rst_bus", 32'h0);
        obs_q.push_back({bus_req, bus_we, bus_be, 26'd0} | bus_addr | bus_wdata);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_read_autoinc;
        dmi_write(A_SBCS, 32'h0015_0000);
        dmi_write(A_ADDR, 32'h0000_1000);
        push_exp("rd_req", 32'h1);           obs_q.push_back(32'(bus_req));
        push_exp("rd_we", 32'h0);            obs_q.push_back(32'(bus_we));
        push_exp("rd_addr", 32'h1000);       obs_q.push_back(bus_addr);
        push_exp("rd_be", 32'hF);            obs_q.push_back(32'(bus_be));
        bus_respond(1'b1, 1'b0, 32'hDEAD_BEEF);
        push_exp("rd_req_done", 32'h0);      obs_q.push_back(32'(bus_req));
        push_exp("rd_data", 32'hDEAD_BEEF);  peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("rd_autoinc", 32'h1004);    peek(A_ADDR, rd); obs_q.push_back(rd);
        push_exp("rd_sbcs", 32'h2015_0407);  peek(A_SBCS, rd); obs_q.push_back(rd);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_byte_lanes;
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0);
        dmi_write(A_ADDR, 32'h2003);
        dmi_write(A_DATA, 32'hA5);
        push_exp("b8_be", 32'h8);            obs_q.push_back(32'(bus_be));
        push_exp("b8_wdata", 32'hA5A5_A5A5); obs_q.push_back(bus_wdata);
        push_exp("b8_we", 32'h1);            obs_q.push_back(32'(bus_we));
        bus_respond(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0002_0000);
        dmi_write(A_ADDR, 32'h2002);
        dmi_write(A_DATA, 32'h1234);
        push_exp("h16_be", 32'hC);            obs_q.push_back(32'(bus_be));
        push_exp("h16_wdata", 32'h1234_1234); obs_q.push_back(bus_wdata);
        bus_respond(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0002_8000);
        dmi_read(A_DATA, rd);
        push_exp("h16_rdret", 32'h1234);      obs_q.push_back(rd);
        push_exp("h16_rbe", 32'hC);           obs_q.push_back(32'(bus_be));
        bus_respond(1'b1, 1'b0, 32'hBEEF_1234);
        push_exp("h16_rdata", 32'hBEEF);      peek(A_DATA, rd); obs_q.push_back(rd);
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0000_8000);
        dmi_write(A_ADDR, 32'h2001);
        dmi_read(A_DATA, rd);
        push_exp("b8_rbe", 32'h2);            obs_q.push_back(32'(bus_be));
        bus_respond(1'b1, 1'b0, 32'h1122_3344);
        push_exp("b8_rdata", 32'h33);         peek(A_DATA, rd); obs_q.push_back(rd);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_alignment;
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0004_0000);
        dmi_write(A_ADDR, 32'h2002);
        dmi_write(A_DATA, 32'h55);
        push_exp("al_noreq", 32'h0);          obs_q.push_back(32'(bus_req));
        push_exp("al_sbcs", 32'h2004_3407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        push_exp("al_data", 32'h55);          peek(A_DATA, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0014_0000);
        dmi_write(A_ADDR, 32'h3000);
        push_exp("al_blocked", 32'h0);        obs_q.push_back(32'(bus_req));
        push_exp("al_addr_upd", 32'h3000);    peek(A_ADDR, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0014_7000);
        push_exp("al_cleared", 32'h2014_0407); peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_ADDR, 32'h3000);
        push_exp("al_restart", 32'h1);        obs_q.push_back(32'(bus_req));
        bus_respond(1'b1, 1'b0, 32'hCAFE_0000);
        push_exp("al_rdata", 32'hCAFE_0000);  peek(A_DATA, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0006_0000);
        dmi_write(A_DATA, 32'h1);
        push_exp("sz_noreq", 32'h0);          obs_q.push_back(32'(bus_req));
        push_exp("sz_sbcs", 32'h2006_4407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0000_7000);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_busy;
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0004_0000);
        dmi_write(A_ADDR, 32'h4000);
        dmi_write(A_DATA, 32'h1111);
        dmi_write(A_DATA, 32'h2222);
        push_exp("by_req", 32'h1);            obs_q.push_back(32'(bus_req));
        dmi_read(A_DATA, rd);
        push_exp("by_held", 32'h1111);        obs_q.push_back(rd);
        push_exp("by_sbcs", 32'h2064_0407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        push_exp("by_wdata", 32'h1111);       obs_q.push_back(bus_wdata);
        bus_respond(1'b1, 1'b0, 32'hFFFF_FFFF);
        push_exp("by_data", 32'h1111);        peek(A_DATA, rd); obs_q.push_back(rd);
        dmi_write(A_DATA, 32'h3333);
        push_exp("by_blocked", 32'h0);        obs_q.push_back(32'(bus_req));
        push_exp("by_sbcs2", 32'h2044_0407);  peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0044_0000);
        push_exp("by_cleared", 32'h2004_0407); peek(A_SBCS, rd); obs_q.push_back(rd);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

`ifdef DM_SBA_TIMEOUT_EN
    task automatic test_timeout;
        int cycles;
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0004_0000);
        dmi_write(A_ADDR, 32'h5000);
        dmi_write(A_DATA, 32'h9);
        cycles = 0;
        while (bus_req && cycles < 50) begin
            cycles++;
            @(negedge clk);
        end
        push_exp("to_cycles", TO);            obs_q.push_back(32'(cycles));
        push_exp("to_sbcs", 32'h2004_1407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0004_7000);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask
`endif

    task automatic test_dmactive;
        @(negedge clk);
        dmi_write(A_SBCS, 32'h0005_0000);
        dmi_write(A_ADDR, 32'h6000);
        dmi_write(A_DATA, 32'hAB);
        push_exp("da_req", 32'h1);            obs_q.push_back(32'(bus_req));
        dmactive = 1'b0;
        @(negedge clk);
        push_exp("da_drop", 32'h0);           obs_q.push_back(32'(bus_req));
        push_exp("da_sbcs", 32'h2000_0407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        push_exp("da_addr", 32'h0);           peek(A_ADDR, rd); obs_q.push_back(rd);
        push_exp("da_data", 32'h0);           peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("da_busaddr", 32'h0);        obs_q.push_back(bus_addr | bus_wdata);
        dmactive = 1'b1;
        @(negedge clk);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_bus_err;
        dmi_write(A_SBCS, 32'h0004_0000);
        dmi_write(A_ADDR, 32'h7000);
        dmi_write(A_DATA, 32'h77);
        bus_respond(1'b1, 1'b0, 32'h0);
        dmi_write(A_SBCS, 32'h0004_8000);
        dmi_read(A_DATA, rd);
        bus_respond(1'b0, 1'b1, 32'hFFFF_FFFF);
        push_exp("be_req", 32'h0);            obs_q.push_back(32'(bus_req));
        push_exp("be_data", 32'h77);          peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("be_sbcs", 32'h2004_A407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0005_F000);
        dmi_read(A_DATA, rd);
        // ack and err together, with a W1C of the error field in the same cycle
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1234_5678;
        dmi_write(A_SBCS, 32'h0005_F000);
        bus_ack = 1'b0; bus_err = 1'b0;
        push_exp("ae_data", 32'h77);          peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("ae_noinc", 32'h7000);       peek(A_ADDR, rd); obs_q.push_back(rd);
        push_exp("ae_sbcs", 32'h2005_A407);   peek(A_SBCS, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0000_7000);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wrap;
        dmi_write(A_SBCS, 32'h0015_8000);
        dmi_write(A_ADDR, 32'h8000);
        for (int i = 0; i < 3; i++) begin
            push_exp($sformatf("bb_req%0d", i), 32'h1);             obs_q.push_back(32'(bus_req));
            push_exp($sformatf("bb_addr%0d", i), 32'h8000 + 4 * i); obs_q.push_back(bus_addr);
            bus_respond(1'b1, 1'b0, 32'h100 + i);
            push_exp($sformatf("bb_idle%0d", i), 32'h0);            obs_q.push_back(32'(bus_req));
            if (i < 2) begin
                dmi_read(A_DATA, rd);
                push_exp($sformatf("bb_ret%0d", i), 32'h100 + i);   obs_q.push_back(rd);
            end
        end
        push_exp("bb_data", 32'h102);         peek(A_DATA, rd); obs_q.push_back(rd);
        push_exp("bb_addr", 32'h800C);        peek(A_ADDR, rd); obs_q.push_back(rd);
        dmi_write(A_SBCS, 32'h0015_0000);
        wrap = 32'hFFFF_FFFC;
        dmi_write(A_ADDR, wrap);
        bus_respond(1'b1, 1'b0, 32'h5);
        wrap = wrap + 32'd4;
        push_exp("wrap_addr", wrap);          peek(A_ADDR, rd); obs_q.push_back(rd);
        push_exp("wrap_data", 32'h5);         peek(A_DATA, rd); obs_q.push_back(rd);
        while (exp_val.size() > 0 && obs_q.size() > 0) begin
            string n; logic [31:0] e, o;
            n = exp_name.pop_front(); e = exp_val.pop_front(); o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin n_mis++; $display("FAIL %s: got 0x%08h, expected 0x%08h", n, o, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_read_autoinc;
        test_byte_lanes;
        test_alignment;
        test_busy;
`ifdef DM_SBA_TIMEOUT_EN
        test_timeout;
`endif
        test_dmactive;
        test_bus_err;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
